// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a programmed value down to 1 and pulses tc,
// either once (one-shot) or repeatedly with automatic reload (periodic).
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             reject
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             busy_q;
  logic             tc_q, tc_d;
  logic             reject_q, reject_d;
  logic             load_ok;

  // A start with a zero value is never accepted, so RUN always holds count >= 1.
  assign load_ok = start && (load_val != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      busy_q   <= (state_d == RUN);
      tc_q     <= tc_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    reject_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_ok) begin
          count_d  = load_val;
          reload_d = load_val;
          mode_d   = mode;
          state_d  = RUN;
        end else if (start) begin
          reject_d = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          count_d = '0;
          state_d = IDLE;
        end else if (load_ok) begin
          count_d  = load_val;
          reload_d = load_val;
          mode_d   = mode;
        end else begin
          // A rejected retrigger falls through to the normal pause/decrement path.
          reject_d = start;
          if (!pause) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign tc     = tc_q;
  assign reject = reject_q;

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

- Synchronous, loadable down-counter and timer.
- Counts a programmed value down to terminal count and flags it with a one-cycle pulse, either once or periodically with automatic reload.
- Complements the team's ripple up-counter: counts in the opposite direction, single clock domain, synchronous reset.
- Used as the interval and timeout generator beside the counter blocks in the same design.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; overrides every other input
- start  input  1  load `load_val` and begin counting (also retriggers while running)
- stop  input  1  abort counting, return to idle
- pause  input  1  freeze count while running
- mode  input  1  0 = one-shot, 1 = periodic; sampled with `start`
- load_val  input  WIDTH  start value N, sampled with `start`
- count  output  WIDTH  current counter value (registered)
- busy  output  1  high while in RUN (registered)
- tc  output  1  terminal-count pulse, one cycle (registered)
- reject  output  1  one-cycle pulse: `start` with `load_val` == 0 was ignored

## Operation
- Internal registers: state (IDLE, RUN), reload_reg[WIDTH-1:0], mode_reg.
- Reset values (after a reset edge):
  - count = 0, busy = 0, tc = 0, reject = 0
  - state = IDLE, reload_reg = 0, mode_reg = 0
- Per-edge priority: reset > stop > start > pause > decrement.
- `tc` and `reject` default to 0 on every edge unless set below.
- IDLE:
  - `start` with `load_val` != 0: count <= load_val, reload_reg <= load_val, mode_reg <= mode, go to RUN.
  - `start` with `load_val` == 0: reject <= 1, stay in IDLE, count unchanged.
  - Otherwise count holds.
- RUN, `stop`: go to IDLE, count <= 0, no tc.
- RUN, `start`: retrigger.
  - With `load_val` != 0: count <= load_val, reload_reg and mode_reg updated, no tc even if count == 1.
  - With `load_val` == 0: reject <= 1 and the edge is otherwise treated as if `start` were low.
- RUN, `pause` (and no stop/start): count, state and reload_reg hold; busy stays 1.
- RUN, decrement edge:
  - count > 1: count <= count - 1.
  - count == 1, mode_reg = 0 (one-shot): count <= 0, tc <= 1, go to IDLE.
  - count == 1, mode_reg = 1 (periodic): count <= reload_reg, tc <= 1, stay in RUN.
- `busy` is the registered equivalent of state == RUN.
- Arithmetic: unsigned and modulo-free.
  - count never underflows, because RUN is never entered with count == 0.
  - load_val = 2^WIDTH-1 is legal.
- `mode`, `load_val` and `pause` are don't-care in IDLE when `start` is low.

## Timing
- Start latency: `start` sampled at edge k → count = N and busy = 1 visible after edge k.
- One-shot:
  - tc is high after edge k+N, assuming no pause cycles.
  - On that same edge count = 0 and busy = 0.
- Periodic:
  - First tc after edge k+N, then every N unpaused edges.
  - count sequence is N, N-1, …, 1, N, …; count never shows 0.
  - N = 1 gives tc high continuously, one pulse per cycle.
- Each paused cycle delays tc by exactly one cycle.
- `stop` or `reset` on the same edge that would produce tc: tc stays 0.
- tc width is always exactly one cycle per terminal event.
- A new `start` may be accepted on the cycle immediately after one-shot completion.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then one-shot start with N=5: count reads 5,4,3,2,1,0; tc high only in the cycle count=0; busy falls in that same cycle.
- Periodic, N=3, run 10 cycles: count 3,2,1,3,2,1,…; tc pulses every 3rd cycle; busy stays 1.
- One-shot N=4 with pause held 2 cycles while count=2: count holds at 2 for those cycles; tc arrives 2 cycles later than unpaused (after edge k+6).
- Retrigger: one-shot N=6 running, at count=1 apply start with load_val=7: count=7, no tc, then a normal countdown to tc.
- Abort paths:
  - `stop` at count=1: count=0, busy=0, tc never asserted.
  - `start` with load_val=0 in IDLE: reject pulses once, busy stays 0.
- Reset mid-run (periodic N=9 at count=4): next cycle count=0, busy=0, tc=0; a following start with N=2 behaves normally.
